gnr_attractor_ctrl: RTL
=======================

# gnr_attractor_ctrl

Controller that drives a bank of two-phase boolean network nodes and reports the transient length (μ) and period (λ) of the attractor reached from a given initial state. It is the driving end of the node interface: it issues `reset_nos`, `init_state`, `start_s0` and `start_s1`, and reads back the concatenated `s0` / `s1` node state vectors. It implements Floyd tortoise/hare detection on the nodes' half-rate `s0` copy and full-rate `s1` copy. It sits between the host/accelerator front end and the node array.

## Interface

Parameters:
- `N_NODES`, 8: number of nodes; width of state vectors.
- `CNT_W`, 16: width of step counters and results.
- `MAX_STEPS`, 1000: per-phase step limit. Must be ≤ 2^CNT_W−1.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `start`  in  1  — run request. Sampled only in IDLE.
- `init_in`  in  N_NODES  — initial network state. Captured when `start` is accepted.
- `busy`  out  1  — high from acceptance until DONE.
- `done`  out  1  — high in DONE. Held until the next accepted `start`.
- `timeout`  out  1  — valid with `done`. 1 means the step limit was hit and the results are invalid.
- `transient`  out  CNT_W  — μ.
- `period`  out  CNT_W  — λ.
- `reset_nos`  out  1  — node reload strobe.
- `init_state`  out  N_NODES  — captured initial vector, driven to the nodes.
- `start_s0`  out  1  — tortoise strobe.
- `start_s1`  out  1  — hare strobe.
- `s0_vec`  in  N_NODES  — node `s0` outputs.
- `s1_vec`  in  N_NODES  — node `s1` outputs.

## Operation

Node contract (relied upon):
- `reset_nos` loads `s0 = s1 = init_state` and sets each node's internal pass bit to 1.
- `start_s1` advances `s1` by one step.
- `start_s0` advances `s0` only when pass=1; every `start_s0` toggles pass.
- Two `start_s0` pulses after a reload therefore advance `s0` by exactly one step.

States: IDLE, LOAD, F_STEP, F_CMP, P_STEP, P_CMP, R_LOAD, R_ADV, T_CMP, T_STEP, T_S0, DONE.

- IDLE: `start`=1 captures `init_in`, clears all counters, clears `done` and `timeout`, and moves to LOAD.
- LOAD: `reset_nos`=1 → F_STEP.
- Phase 1, meet:
  - F_STEP: `start_s0` = `start_s1` = 1; `hare_cnt`++.
  - F_CMP: if `hare_cnt` ≥ 2 and `s0_vec` == `s1_vec`, latch `meet` = `s1_vec`, clear `per_cnt`, go to P_STEP.
  - F_CMP otherwise: if `hare_cnt` == MAX_STEPS → DONE with `timeout`=1; else → F_STEP.
  - Comparison at `hare_cnt` = 1 is masked, because both copies trivially equal f(x0).
- Phase 2, period:
  - P_STEP: `start_s1` only; `per_cnt`++.
  - P_CMP: if `s1_vec` == `meet`, `period` = `per_cnt` and go to R_LOAD.
  - P_CMP otherwise: timeout check as in F_CMP, then → P_STEP.
- Phase 3, transient:
  - R_LOAD: `reset_nos`=1; clear `adv_cnt` and `tr_cnt`.
  - R_ADV: `start_s1` only; `adv_cnt`++. Repeat until `adv_cnt` == `period`, then → T_CMP.
  - T_CMP: if `s0_vec` == `s1_vec`, `transient` = `tr_cnt` and go to DONE.
  - T_CMP otherwise: timeout check on `tr_cnt`, then → T_STEP.
  - T_STEP: `start_s0` = `start_s1` = 1; `tr_cnt`++ → T_S0.
  - T_S0: `start_s0` only, which restores node pass to 1 → T_CMP.
- DONE: `done`=1, `busy`=0. `start` re-arms directly (same behaviour as in IDLE).
- Strobe outputs are combinational decodes of state. At most one phase's strobes are active per cycle. `reset_nos` is never asserted together with a step strobe.

## Timing

- Reset (`rst_n`=0, immediate, no clock needed):
  - state = IDLE;
  - `busy`, `done`, `timeout`, `transient`, `period`, `reset_nos`, `start_s0`, `start_s1` = 0;
  - `init_state` = 0.
- Node vectors are registered. A strobe in cycle c is visible on `s*_vec` in cycle c+1, which is why every step state is followed by a compare state.
- Phase 1 costs 2 cycles per hare step. Phase 2 costs 2 cycles per step. R_ADV costs 1 cycle per step. Phase 3 costs 3 cycles per transient step.
- Fixed-point case (f(x0) = x0): `start` sampled at edge E0 → LOAD in cycle 1 → `done`=1 in cycle 11, with `period`=1 and `transient`=0.
- `start` while busy is ignored.
- `rst_n` asserted mid-run aborts immediately. Node registers are left as-is and are reloaded by the next run's LOAD.
- Results are stable from DONE entry until the next accepted `start`.

## Test plan

- Fixed point, N_NODES=4, node model f(x)=x, init 4'h9 → `done` at cycle 11, `period`=1, `transient`=0, `timeout`=0.
- Ring counter, f(x)=x+1 mod 16, init 0 → `period`=16, `transient`=0.
- Saturating map, f(x)=min(x+1, 5), init 0 → `period`=1, `transient`=5. Check exactly 5 T_STEP strobes, each followed by one T_S0-only strobe.
- Timeout: MAX_STEPS=8, f(x)=x+1 mod 16 → `done`=1, `timeout`=1, at most 8 F_STEP strobes issued.
- Protocol checks:
  - `start` pulsed during phase 2 → ignored, results unchanged.
  - `start` in DONE → new run; `done` drops the next cycle.
- Reset abort: `rst_n` low mid-P_CMP, between clock edges → all outputs 0 immediately. A new run with init 4'h3 on ring counter → `period`=16.

Source files
------------

// File: rtl/gnr_attractor_ctrl.sv
// Floyd cycle detection over a two-phase boolean node bank: finds the
// attractor period (lambda) and the transient length (mu) from a given start.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | reload nodes with the captured initial vector
// F_STEP | tortoise and hare strobe (tortoise moves every second pulse)
// F_CMP  | compare s0/s1 for the meeting point
// P_STEP | hare-only step around the cycle
// P_CMP  | compare hare against the meeting point
// R_LOAD | reload nodes for the transient search
// R_ADV  | advance hare by one period
// T_CMP  | compare s0/s1 for the cycle entry
// T_STEP | step both copies
// T_S0   | extra tortoise strobe that restores the pass bit
// DONE   | results valid
module gnr_attractor_ctrl #(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_NODES-1:0] init_in,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   transient,
    output logic [CNT_W-1:0]   period,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C = CNT_W'(2);

    typedef enum logic [3:0] {
        IDLE, LOAD, F_STEP, F_CMP, P_STEP, P_CMP,
        R_LOAD, R_ADV, T_CMP, T_STEP, T_S0, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N_NODES-1:0] init_q, init_d;
    logic [N_NODES-1:0] meet_q, meet_d;
    logic [CNT_W-1:0]   hare_q, hare_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic [CNT_W-1:0]   adv_q, adv_d;
    logic [CNT_W-1:0]   tr_q, tr_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   transient_q, transient_d;
    logic               timeout_q, timeout_d;

    logic             f_hit, p_hit, t_hit;
    logic [CNT_W-1:0] adv_inc;

    // hare_cnt == 1 is masked: both copies trivially hold f(x0) there
    assign f_hit   = (hare_q >= TWO_C) && (s0_vec == s1_vec);
    assign p_hit   = (s1_vec == meet_q);
    assign t_hit   = (s0_vec == s1_vec);
    assign adv_inc = adv_q + ONE_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q      <= '0;
            meet_q      <= '0;
            hare_q      <= '0;
            per_q       <= '0;
            adv_q       <= '0;
            tr_q        <= '0;
            period_q    <= '0;
            transient_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            init_q      <= init_d;
            meet_q      <= meet_d;
            hare_q      <= hare_d;
            per_q       <= per_d;
            adv_q       <= adv_d;
            tr_q        <= tr_d;
            period_q    <= period_d;
            transient_q <= transient_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = LOAD;
            LOAD:       state_d = F_STEP;
            F_STEP:     state_d = F_CMP;
            F_CMP: begin
                if (f_hit)                state_d = P_STEP;
                else if (hare_q == MAX_C) state_d = DONE;
                else                      state_d = F_STEP;
            end
            P_STEP:     state_d = P_CMP;
            P_CMP: begin
                if (p_hit)               state_d = R_LOAD;
                else if (per_q == MAX_C) state_d = DONE;
                else                     state_d = P_STEP;
            end
            R_LOAD:     state_d = R_ADV;
            R_ADV:      if (adv_inc == period_q) state_d = T_CMP;
            T_CMP: begin
                if (t_hit)              state_d = DONE;
                else if (tr_q == MAX_C) state_d = DONE;
                else                    state_d = T_STEP;
            end
            T_STEP:     state_d = T_S0;
            T_S0:       state_d = T_CMP;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        init_d      = init_q;
        meet_d      = meet_q;
        hare_d      = hare_q;
        per_d       = per_q;
        adv_d       = adv_q;
        tr_d        = tr_q;
        period_d    = period_q;
        transient_d = transient_q;
        timeout_d   = timeout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    init_d    = init_in;
                    hare_d    = '0;
                    per_d     = '0;
                    adv_d     = '0;
                    tr_d      = '0;
                    timeout_d = 1'b0;
                end
            end
            F_STEP: hare_d = hare_q + ONE_C;
            F_CMP: begin
                if (f_hit) begin
                    meet_d = s1_vec;
                    per_d  = '0;
                end else if (hare_q == MAX_C) begin
                    timeout_d = 1'b1;
                end
            end
            P_STEP: per_d = per_q + ONE_C;
            P_CMP: begin
                if (p_hit)               period_d  = per_q;
                else if (per_q == MAX_C) timeout_d = 1'b1;
            end
            R_LOAD: begin
                adv_d = '0;
                tr_d  = '0;
            end
            R_ADV:  adv_d = adv_inc;
            T_CMP: begin
                if (t_hit)              transient_d = tr_q;
                else if (tr_q == MAX_C) timeout_d   = 1'b1;
            end
            T_STEP: tr_d = tr_q + ONE_C;
            default: ;
        endcase
    end

    always_comb begin
        reset_nos = (state_q == LOAD) || (state_q == R_LOAD);
        start_s0  = (state_q == F_STEP) || (state_q == T_STEP) || (state_q == T_S0);
        start_s1  = (state_q == F_STEP) || (state_q == P_STEP) ||
                    (state_q == R_ADV)  || (state_q == T_STEP);
        busy      = (state_q != IDLE) && (state_q != DONE);
        done      = (state_q == DONE);
    end

    assign timeout    = timeout_q;
    assign transient  = transient_q;
    assign period     = period_q;
    assign init_state = init_q;

endmodule
